xadc_drp_reader: RTL

Sequencer sitting directly downstream of the XADC wizard's DRP port. On every end-of-sequence pulse it reads the auxiliary channel 4 and channel 12 result registers over DRP and publishes the pair as one 12-bit sample pair on a valid/ready stream. It also detects DRP timeouts and counts sequences dropped because the consumer was slow.

---
 rtl/xadc_pkg.sv | 20 ++
 rtl/xadc_drp_reader.sv | 115 +++++++++++
 2 files changed

// File: rtl/xadc_pkg.sv
// xadc_pkg: state encoding, DRP addresses and result-field bounds shared by the XADC DRP reader.
package xadc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        WAIT_A,
        REQ_B,
        WAIT_B,
        OUTPUT
    } xadc_drp_reader_state_t;

    localparam logic [6:0] VAUX4_ADDR  = 7'h14;
    localparam logic [6:0] VAUX12_ADDR = 7'h1C;

    localparam int RES_MSB = 15;
    localparam int RES_LSB = 4;
    localparam int RES_W   = RES_MSB - RES_LSB + 1;

endpackage

// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader: on each XADC end-of-sequence reads two aux result registers over DRP and
// publishes them as a sample pair on a valid/ready stream, flagging DRP timeouts and dropped sequences.
module xadc_drp_reader
    import xadc_pkg::*;
#(
    parameter logic [6:0]  CH_A_ADDR   = VAUX4_ADDR,
    parameter logic [6:0]  CH_B_ADDR   = VAUX12_ADDR,
    parameter int unsigned DRP_TIMEOUT = 16
) (
    input  logic             dclk_in,
    input  logic             reset_n_in,
    input  logic             eos_in,
    output logic             den_out,
    output logic             dwe_out,
    output logic [6:0]       daddr_out,
    output logic [15:0]      di_out,
    input  logic             drdy_in,
    input  logic [15:0]      do_in,
    output logic [RES_W-1:0] sample_a_out,
    output logic [RES_W-1:0] sample_b_out,
    output logic             sample_valid_out,
    input  logic             sample_ready_in,
    output logic             timeout_out,
    output logic [7:0]       overrun_count_out
);

    // The timer starts at 0 on the first WAIT cycle, so this value is reached DRP_TIMEOUT-1 cycles after den.
    localparam logic [7:0] TMO_LAST = 8'(DRP_TIMEOUT - 2);

    xadc_drp_reader_state_t state;
    logic [7:0]       timer;
    logic [RES_W-1:0] a_reg;
    logic             handshake;
    logic             in_wait;
    logic             timed_out;
    logic             do_unused;

    assign handshake = (state == OUTPUT) && sample_ready_in;
    assign in_wait   = (state == WAIT_A) || (state == WAIT_B);
    assign timed_out = in_wait && !drdy_in && (timer == TMO_LAST);
    assign do_unused = ^do_in[RES_LSB-1:0];
    assign dwe_out   = 1'b0;
    assign di_out    = '0;

    always_ff @(posedge dclk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state             <= IDLE;
            timer             <= '0;
            a_reg             <= '0;
            den_out           <= 1'b0;
            daddr_out         <= '0;
            sample_a_out      <= '0;
            sample_b_out      <= '0;
            sample_valid_out  <= 1'b0;
            timeout_out       <= 1'b0;
            overrun_count_out <= '0;
        end else begin
            den_out     <= 1'b0;
            timeout_out <= timed_out;
            if (eos_in && state != IDLE && !handshake && overrun_count_out != 8'hFF)
                overrun_count_out <= overrun_count_out + 8'd1;
            if (in_wait)
                timer <= timer + 8'd1;
            case (state)
                IDLE: begin
                    if (eos_in) begin
                        state     <= REQ_A;
                        den_out   <= 1'b1;
                        daddr_out <= CH_A_ADDR;
                    end
                end
                REQ_A: begin
                    state <= WAIT_A;
                    timer <= '0;
                end
                WAIT_A: begin
                    if (drdy_in) begin
                        a_reg     <= do_in[RES_MSB:RES_LSB];
                        state     <= REQ_B;
                        den_out   <= 1'b1;
                        daddr_out <= CH_B_ADDR;
                    end else if (timed_out) begin
                        state <= IDLE;
                    end
                end
                REQ_B: begin
                    state <= WAIT_B;
                    timer <= '0;
                end
                WAIT_B: begin
                    if (drdy_in) begin
                        sample_a_out     <= a_reg;
                        sample_b_out     <= do_in[RES_MSB:RES_LSB];
                        sample_valid_out <= 1'b1;
                        state            <= OUTPUT;
                    end else if (timed_out) begin
                        state <= IDLE;
                    end
                end
                OUTPUT: begin
                    if (sample_ready_in) begin
                        sample_valid_out <= 1'b0;
                        state            <= eos_in ? REQ_A : IDLE;
                        if (eos_in) begin
                            den_out   <= 1'b1;
                            daddr_out <= CH_A_ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
